// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA frame scheduler: timing limits,
// board geometry, the display-layer encoding and the update FSM states.
package vga_pkg;

   localparam logic [9:0]  H_ACTIVE   = 10'd640;
   localparam logic [9:0]  V_ACTIVE   = 10'd480;
   localparam int unsigned FRAME_W    = 32'd8;
   localparam int unsigned BLINK_LOG2 = 32'd5;
   localparam int unsigned CELLS      = 32'd81;
   localparam int unsigned BOARD_W    = 32'd324;

   typedef enum logic [1:0] {
      LAYER_BOARD = 2'd0,
      LAYER_TRACK = 2'd1,
      LAYER_MOUSE = 2'd2,
      LAYER_BLACK = 2'd3
   } layer_e;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT_VB = 2'd1,
      S_ACK     = 2'd2
   } fsm_state_e;

   // Blanking wins over every overlay; the mouse overlay sits above the track.
   function automatic layer_e layer_pick(input logic vis, input logic mouse, input logic track);
      layer_e l;
      if (!vis) begin
         l = LAYER_BLACK;
      end else if (mouse) begin
         l = LAYER_MOUSE;
      end else if (track) begin
         l = LAYER_TRACK;
      end else begin
         l = LAYER_BOARD;
      end
      return l;
   endfunction

endpackage

// File: rtl/vga_frame_scheduler_if.sv
// Update channel between game logic (master) and the frame scheduler (slave):
// request, the board snapshot offered with it, and the commit acknowledge.
interface vga_frame_scheduler_if;
   import vga_pkg::*;

   logic               upd_req;
   logic [BOARD_W-1:0] board_in;
   logic [CELLS-1:0]   board_blank_in;
   logic [1:0]         state_in;
   logic               upd_ack;

   modport master (
      output upd_req,
      output board_in,
      output board_blank_in,
      output state_in,
      input  upd_ack
   );

   modport slave (
      input  upd_req,
      input  board_in,
      input  board_blank_in,
      input  state_in,
      output upd_ack
   );

endinterface

// File: rtl/vga_vblank_detect.sv
// Detects entry into vertical blanking from the raster line counter and
// counts completed frames.
module vga_vblank_detect
   import vga_pkg::*;
(
   input  logic               clka,
   input  logic               rst,
   input  logic [9:0]         v_cnt,
   output logic               vblank_start,
   output logic [FRAME_W-1:0] frame_cnt
);

   logic [9:0]         v_cnt_d_r;
   logic               vblank_start_r;
   logic [FRAME_W-1:0] frame_cnt_r;

   // Pulse only on the first cycle of line V_ACTIVE; the frame count follows the pulse.
   always_ff @(posedge clka) begin
      if (rst) begin
         v_cnt_d_r      <= 10'd0;
         vblank_start_r <= 1'b0;
         frame_cnt_r    <= {FRAME_W{1'b0}};
      end else begin
         v_cnt_d_r      <= v_cnt;
         vblank_start_r <= (v_cnt == V_ACTIVE) && (v_cnt_d_r != V_ACTIVE);
         if (vblank_start_r) begin
            frame_cnt_r <= frame_cnt_r + {{(FRAME_W-1){1'b0}}, 1'b1};
         end
      end
   end

   assign vblank_start = vblank_start_r;
   assign frame_cnt    = frame_cnt_r;

endmodule

// File: rtl/vga_frame_scheduler.sv
// Frame-synchronous update scheduler: stages board updates from game logic and
// commits them to the pixel path's shadow copy only at the start of vertical blanking.
module vga_frame_scheduler
   import vga_pkg::*;
(
   input  logic                      clka,
   input  logic                      rst,
   input  logic [9:0]                h_cnt,
   input  logic [9:0]                v_cnt,
   input  logic                      valid,
   vga_frame_scheduler_if.slave      upd,
   input  logic                      enable_mouse_display,
   input  logic                      enable_track_display,
   output logic [BOARD_W-1:0]        board_out,
   output logic [CELLS-1:0]          board_blank_out,
   output logic [1:0]                state_out,
   output logic                      vblank_start,
   output logic [FRAME_W-1:0]        frame_cnt,
   output logic                      blink,
   output logic [1:0]                layer_sel
);

   fsm_state_e         state_r;
   fsm_state_e         state_nxt_s;
   logic               capture_s;
   logic               commit_s;
   logic               upd_ack_r;
   logic               vblank_start_s;
   logic [BOARD_W-1:0] stage_board_r;
   logic [CELLS-1:0]   stage_blank_r;
   logic [1:0]         stage_state_r;
   logic [BOARD_W-1:0] board_r;
   logic [CELLS-1:0]   blank_r;
   logic [1:0]         state_out_r;
   layer_e             layer_r;
   logic               unused_h_cnt_s;

   // Line position is not needed for frame-level scheduling.
   assign unused_h_cnt_s = ^{h_cnt, H_ACTIVE};

   vga_vblank_detect u_vblank_detect (
      .clka         (clka),
      .rst          (rst),
      .v_cnt        (v_cnt),
      .vblank_start (vblank_start_s),
      .frame_cnt    (frame_cnt)
   );

   // Handshake FSM: capture in IDLE, commit on the vblank pulse, then one ack cycle.
   always_comb begin
      state_nxt_s = state_r;
      capture_s   = 1'b0;
      commit_s    = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (upd.upd_req) begin
               capture_s   = 1'b1;
               state_nxt_s = S_WAIT_VB;
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_WAIT_VB: begin
            if (vblank_start_s) begin
               commit_s    = 1'b1;
               state_nxt_s = S_ACK;
            end else begin
               state_nxt_s = S_WAIT_VB;
            end
         end
         S_ACK: begin
            state_nxt_s = S_IDLE;
         end
         default: begin
            state_nxt_s = S_IDLE;
         end
      endcase
   end

   // State register; the ack is registered off the ACK state so it trails the commit by one cycle.
   always_ff @(posedge clka) begin
      if (rst) begin
         state_r   <= S_IDLE;
         upd_ack_r <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         upd_ack_r <= (state_r == S_ACK);
      end
   end

   // Staging captures the request snapshot; the shadow copy only moves on commit.
   always_ff @(posedge clka) begin
      if (rst) begin
         stage_board_r <= {BOARD_W{1'b0}};
         stage_blank_r <= {CELLS{1'b0}};
         stage_state_r <= 2'd0;
         board_r       <= {BOARD_W{1'b0}};
         blank_r       <= {CELLS{1'b1}};
         state_out_r   <= 2'd0;
      end else begin
         if (capture_s) begin
            stage_board_r <= upd.board_in;
            stage_blank_r <= upd.board_blank_in;
            stage_state_r <= upd.state_in;
         end
         if (commit_s) begin
            board_r     <= stage_board_r;
            blank_r     <= stage_blank_r;
            state_out_r <= stage_state_r;
         end
      end
   end

   // One-cycle delay lines the layer select up with the pixel generator's memory read.
   always_ff @(posedge clka) begin
      if (rst) begin
         layer_r <= LAYER_BLACK;
      end else begin
         layer_r <= layer_pick(valid, enable_mouse_display, enable_track_display);
      end
   end

   assign upd.upd_ack     = upd_ack_r;
   assign board_out       = board_r;
   assign board_blank_out = blank_r;
   assign state_out       = state_out_r;
   assign vblank_start    = vblank_start_s;
   assign blink           = frame_cnt[BLINK_LOG2];
   assign layer_sel       = layer_r;

endmodule
